// File: rtl/ps2_mouse_init_seq_if.sv
// Signal bundle between the PS/2 init sequencer and its surroundings.
// The pad inputs are raw; the oe outputs drive open-drain pulldowns.
interface ps2_mouse_init_seq_if;
    logic       start;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] step;

    modport master (
        input  start, ps2_clk_i, ps2_dat_i,
        output ps2_clk_oe, ps2_dat_oe, busy, done, error, rx_data, rx_valid, step
    );

    modport slave (
        output start, ps2_clk_i, ps2_dat_i,
        input  ps2_clk_oe, ps2_dat_oe, busy, done, error, rx_data, rx_valid, step
    );
endinterface

// File: rtl/ps2_mouse_init_seq.sv
// Host-side PS/2 sequencer: sends RESET, SET_RATE + rate and ENABLE to the mouse,
// validates every response and resends a command until its retry budget runs out.
module ps2_mouse_init_seq #(
    parameter int         INHIBIT_CYC = 2500,
    parameter int         TIMEOUT_CYC = 500000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input logic                  clk,
    input logic                  rst,
    ps2_mouse_init_seq_if.master bus
);

    localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, RTS, TX, ACK, RX, CHECK, RETRY, DONE, ERROR
    } state_t;

    state_t           state;
    logic             clk_s1, clk_s2, clk_d, dat_s1, dat_s2, fall;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_nxt;
    logic [9:0]       shreg;
    logic [10:0]      frame;
    logic [RTY_W-1:0] retry;
    logic [RTY_W-1:0] retry_nxt;
    logic [1:0]       resp_idx;
    logic [7:0]       cmd;
    logic             chk_more, chk_adv;

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'hFF;
            2'd1:    return 8'hF3;
            2'd2:    return SAMPLE_RATE;
            default: return 8'hF4;
        endcase
    endfunction

    function automatic logic frame_ok(input logic [10:0] f);
        return !f[0] && f[10] && (^f[9:1]);
    endfunction

    assign cmd       = cmd_byte(bus.step);
    assign frame     = {dat_s2, shreg};
    assign retry_nxt = retry + RTY_W'(1);
    assign bit_nxt   = bit_cnt + 4'd1;

    // Response after RESET is FA, AA, 00; every other command answers FA alone
    always_comb begin
        chk_more = 1'b0;
        chk_adv  = 1'b0;
        case (resp_idx)
            2'd0: begin
                chk_more = (bus.rx_data == 8'hFA) && (bus.step == 2'd0);
                chk_adv  = (bus.rx_data == 8'hFA) && (bus.step != 2'd0);
            end
            2'd1:    chk_more = (bus.rx_data == 8'hAA);
            default: chk_adv  = (bus.rx_data == 8'h00);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            fall   <= 1'b0;
        end else begin
            clk_s1 <= bus.ps2_clk_i;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= bus.ps2_dat_i;
            dat_s2 <= dat_s1;
            fall   <= clk_d & ~clk_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            retry          <= '0;
            resp_idx       <= '0;
            bus.ps2_clk_oe <= 1'b0;
            bus.ps2_dat_oe <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.step       <= '0;
        end else begin
            bus.rx_valid <= 1'b0;

            // Bus-phase watchdog; a device clock edge in the same cycle takes priority
            if (state inside {RTS, TX, ACK, RX}) begin
                if (fall) begin
                    cnt <= '0;
                end else if (cnt == TMO_LAST) begin
                    state          <= RETRY;
                    bus.ps2_clk_oe <= 1'b0;
                    bus.ps2_dat_oe <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state          <= INHIBIT;
                        bus.step       <= '0;
                        retry          <= '0;
                        resp_idx       <= '0;
                        bus.done       <= 1'b0;
                        bus.error      <= 1'b0;
                        bus.busy       <= 1'b1;
                        bus.ps2_clk_oe <= 1'b1;
                        cnt            <= '0;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        bus.ps2_clk_oe <= 1'b0;
                        bus.ps2_dat_oe <= 1'b1;
                        cnt            <= '0;
                        state          <= RTS;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RTS: begin
                    if (fall) begin
                        bus.ps2_dat_oe <= ~cmd[0];
                        bit_cnt        <= 4'd1;
                        state          <= TX;
                    end
                end
                TX: begin
                    if (fall) begin
                        bit_cnt <= bit_nxt;
                        if (bit_nxt <= 4'd8) begin
                            bus.ps2_dat_oe <= ~cmd[bit_cnt[2:0]];
                        end else if (bit_nxt == 4'd9) begin
                            // odd parity bit is ~^cmd, so the pulldown is its inverse
                            bus.ps2_dat_oe <= ^cmd;
                        end else begin
                            bus.ps2_dat_oe <= 1'b0;
                            state          <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
                        bit_cnt <= '0;
                        state   <= dat_s2 ? RETRY : RX;
                    end
                end
                RX: begin
                    if (fall) begin
                        shreg   <= {dat_s2, shreg[9:1]};
                        bit_cnt <= bit_nxt;
                        if (bit_cnt == 4'd10) begin
                            if (frame_ok(frame)) begin
                                bus.rx_data  <= frame[8:1];
                                bus.rx_valid <= 1'b1;
                                state        <= CHECK;
                            end else begin
                                state <= RETRY;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (chk_more) begin
                        resp_idx <= resp_idx + 2'd1;
                        bit_cnt  <= '0;
                        cnt      <= '0;
                        state    <= RX;
                    end else if (chk_adv) begin
                        retry    <= '0;
                        resp_idx <= '0;
                        if (bus.step == 2'd3) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= DONE;
                        end else begin
                            bus.step       <= bus.step + 2'd1;
                            bus.ps2_clk_oe <= 1'b1;
                            cnt            <= '0;
                            state          <= INHIBIT;
                        end
                    end else begin
                        state <= RETRY;
                    end
                end
                RETRY: begin
                    retry    <= retry_nxt;
                    resp_idx <= '0;
                    if (retry_nxt > RTY_LIM) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= ERROR;
                    end else begin
                        bus.ps2_clk_oe <= 1'b1;
                        cnt            <= '0;
                        state          <= INHIBIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Directed bench: a PS/2 device model on open-drain lines drives the init sequencer
// through normal, resend, no-ack, stalled-clock and reset scenarios.
module tb_ps2_mouse_init_seq;

    localparam int INH  = 2500;
    localparam int TMO  = 1000;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_mouse_init_seq_if bus();

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    assign bus.ps2_clk_i = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_i = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_mouse_init_seq #(
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TMO),
        .MAX_RETRY  (3),
        .SAMPLE_RATE(8'd100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int hi_run = 0, last_hi_run = 0, rxv_cnt = 0;
    logic [11:0] f4_bits;

    always @(posedge clk) begin
        if (bus.ps2_clk_oe) hi_run <= hi_run + 1;
        else begin
            if (hi_run != 0) last_hi_run <= hi_run;
            hi_run <= 0;
        end
        if (bus.rx_valid) rxv_cnt <= rxv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_clk_oe"}, bus.ps2_clk_oe, 0);
        check({tag, "_dat_oe"}, bus.ps2_dat_oe, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
        check({tag, "_rx_data"}, bus.rx_data, 0);
        check({tag, "_rx_valid"}, bus.rx_valid, 0);
        check({tag, "_step"}, bus.step, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_rts(input string tag);
        int t = 0;
        while (!(bus.ps2_clk_i === 1'b1 && bus.ps2_dat_i === 1'b0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_rts_seen"}, (t < 20000), 1);
        repeat (2) @(negedge clk);
    endtask

    // Device-generated clock for a host-to-device frame; bits[k] is the line at rising k
    task automatic dev_recv(input bit do_ack, input int nclk, output logic [11:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k] = bus.ps2_dat_i;
            repeat (HALF / 2) @(negedge clk);
            if (k == 10 && do_ack) dev_dat_low = 1'b1;
            if (k == 11) dev_dat_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    task automatic dev_send(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        repeat (2 * HALF) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            dev_dat_low = ~f[k];
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic dev_cmd(input logic [7:0] exp_cmd, input string tag, output logic [11:0] bits);
        wait_rts(tag);
        check({tag, "_inhibit_len"}, last_hi_run, INH);
        dev_recv(1'b1, 11, bits);
        check({tag, "_byte"}, bits[8:1], exp_cmd);
        check({tag, "_parity"}, bits[9], ~^exp_cmd);
        check({tag, "_stop"}, bits[10], 1'b1);
    endtask

    task automatic full_seq(input string tag, input bit fe_on_f3);
        logic [11:0] bits;
        dev_cmd(8'hFF, {tag, "_ff"}, bits);
        dev_send(8'hFA, 11);
        dev_send(8'hAA, 11);
        dev_send(8'h00, 11);
        dev_cmd(8'hF3, {tag, "_f3"}, bits);
        if (fe_on_f3) begin
            dev_send(8'hFE, 11);
            dev_cmd(8'hF3, {tag, "_f3_resend"}, bits);
        end
        dev_send(8'hFA, 11);
        dev_cmd(8'h64, {tag, "_rate"}, bits);
        dev_send(8'hFA, 11);
        dev_cmd(8'hF4, {tag, "_f4"}, bits);
        f4_bits = bits;
        dev_send(8'hFA, 11);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [11:0] bits;
        logic [8:0]  f4_wire;
        int          base;
        int          t;
        f4_wire   = 9'b0_1111_0100;
        bus.start = 1'b0;
        rst       = 1'b1;
        repeat (4) @(negedge clk);
        check_cleared("reset_held");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset_released");

        // Normal sequence plus wire-level bit check of ENABLE
        base = rxv_cnt;
        pulse_start();
        check("t1_busy_running", bus.busy, 1);
        full_seq("t1", 1'b0);
        check("t1_done", bus.done, 1);
        check("t1_error", bus.error, 0);
        check("t1_busy_end", bus.busy, 0);
        check("t1_step", bus.step, 3);
        check("t1_rx_pulses", rxv_cnt - base, 6);
        check("t1_rx_data", bus.rx_data, 8'hFA);
        for (int k = 1; k <= 9; k++)
            check($sformatf("t2_f4_bit%0d", k), f4_bits[k], f4_wire[k-1]);

        // SET_RATE answered with FE once
        base = rxv_cnt;
        pulse_start();
        check("t3_done_cleared", bus.done, 0);
        full_seq("t3", 1'b1);
        check("t3_done", bus.done, 1);
        check("t3_error", bus.error, 0);
        check("t3_rx_pulses", rxv_cnt - base, 7);

        // RESET never acknowledged
        pulse_start();
        for (int a = 0; a < 4; a++) begin
            wait_rts($sformatf("t4_try%0d", a));
            dev_recv(1'b0, 11, bits);
            check($sformatf("t4_try%0d_byte", a), bits[8:1], 8'hFF);
        end
        repeat (20) @(negedge clk);
        check("t4_error", bus.error, 1);
        check("t4_done", bus.done, 0);
        check("t4_step", bus.step, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_clk_oe", bus.ps2_clk_oe, 0);
        check("t4_dat_oe", bus.ps2_dat_oe, 0);
        repeat (INH + 500) @(negedge clk);
        check("t4_no_fifth_try", bus.ps2_clk_oe, 0);

        // Device stops clocking after four bits of RESET
        pulse_start();
        check("t5_error_cleared", bus.error, 0);
        wait_rts("t5_first");
        dev_recv(1'b1, 4, bits);
        check("t5_partial_bits", bits[3:1], 3'b111);
        t = 0;
        while (bus.ps2_clk_oe !== 1'b1 && t < 3 * TMO) begin
            @(negedge clk);
            t++;
        end
        check("t5_timeout_window", (t + 2 * HALF >= TMO) && (t + 2 * HALF <= TMO + 10), 1);
        check("t5_busy_after_timeout", bus.busy, 1);
        full_seq("t5", 1'b0);
        check("t5_done", bus.done, 1);
        check("t5_error", bus.error, 0);

        // Reset while the host holds msclk low
        pulse_start();
        repeat (100) @(negedge clk);
        check("t6_inhibit_clk_oe", bus.ps2_clk_oe, 1);
        rst = 1'b1;
        #1;
        check("t6_async_clk_oe", bus.ps2_clk_oe, 0);
        check("t6_async_busy", bus.busy, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the AA frame, then a clean run
        pulse_start();
        dev_cmd(8'hFF, "t6_ff", bits);
        dev_send(8'hFA, 11);
        dev_send(8'hAA, 5);
        check("t6_rx_before", bus.rx_data, 8'hFA);
        check("t6_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_cleared("t6_mid_rx");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        base = rxv_cnt;
        pulse_start();
        full_seq("t6", 1'b0);
        check("t6_done", bus.done, 1);
        check("t6_error", bus.error, 0);
        check("t6_rx_pulses", rxv_cnt - base, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
